// File: rtl/sram_port_ctrl_if.sv
// Request/response channels between the core's memory masters and sram_port_ctrl.
// The data channel carries loads and stores; the fetch channel is read-only.
interface sram_port_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_WMASKS = 4
);
    logic                  d_req_valid;
    logic                  d_req_ready;
    logic                  d_req_we;
    logic [NUM_WMASKS-1:0] d_req_wmask;
    logic [ADDR_WIDTH-1:0] d_req_addr;
    logic [DATA_WIDTH-1:0] d_req_wdata;
    logic                  d_rsp_valid;
    logic                  d_rsp_ready;
    logic [DATA_WIDTH-1:0] d_rsp_rdata;

    logic                  i_req_valid;
    logic                  i_req_ready;
    logic [ADDR_WIDTH-1:0] i_req_addr;
    logic                  i_rsp_valid;
    logic                  i_rsp_ready;
    logic [DATA_WIDTH-1:0] i_rsp_rdata;

    modport master (
        output d_req_valid, d_req_we, d_req_wmask, d_req_addr, d_req_wdata, d_rsp_ready,
        output i_req_valid, i_req_addr, i_rsp_ready,
        input  d_req_ready, d_rsp_valid, d_rsp_rdata,
        input  i_req_ready, i_rsp_valid, i_rsp_rdata
    );

    modport slave (
        input  d_req_valid, d_req_we, d_req_wmask, d_req_addr, d_req_wdata, d_rsp_ready,
        input  i_req_valid, i_req_addr, i_rsp_ready,
        output d_req_ready, d_rsp_valid, d_rsp_rdata,
        output i_req_ready, i_rsp_valid, i_rsp_rdata
    );
endinterface

// File: rtl/sram_port_ctrl.sv
// Front-end for the dual-port SRAM macro: drives active-low pins from the two request
// channels and buffers returned read data in credit-managed per-channel response FIFOs.
module sram_port_ctrl_rsp_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + (PW+1)'(1);
                2'b01:   cnt <= cnt - (PW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign valid = (cnt != '0);
    assign count = cnt;
endmodule

module sram_port_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_WMASKS = 4,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sram_port_ctrl_if.slave       bus,
    output logic                  csb0,
    output logic                  web0,
    output logic [NUM_WMASKS-1:0] wmask0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0,
    output logic                  csb1,
    output logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] dout1
);
    localparam int CW = $clog2(RSP_DEPTH);
    localparam logic [CW:0] DEPTH_V = (CW+1)'(RSP_DEPTH);

    logic            d_fire, d_rd_fire, i_fire;
    logic            d_inflight, i_inflight;
    logic            d_valid, i_valid;
    logic            d_pop, i_pop;
    logic            d_credit, i_credit, hazard;
    logic [CW:0]     d_count, i_count, d_occ, i_occ;
    logic [DATA_WIDTH-1:0] d_rdata, i_rdata;

    // An entry popped this cycle frees its slot immediately so reads sustain 1/cycle.
    assign d_occ    = d_count + (CW+1)'(d_inflight) - (CW+1)'(d_pop);
    assign i_occ    = i_count + (CW+1)'(i_inflight) - (CW+1)'(i_pop);
    assign d_credit = d_occ < DEPTH_V;
    assign i_credit = i_occ < DEPTH_V;

    assign hazard = bus.d_req_valid & bus.d_req_we & (bus.d_req_addr == bus.i_req_addr);

    assign bus.d_req_ready = rst_n & (bus.d_req_we | d_credit);
    assign bus.i_req_ready = rst_n & i_credit & ~hazard;

    assign d_fire    = bus.d_req_valid & bus.d_req_ready;
    assign d_rd_fire = d_fire & ~bus.d_req_we;
    assign i_fire    = bus.i_req_valid & bus.i_req_ready;

    assign csb0   = ~d_fire;
    assign web0   = ~(rst_n & bus.d_req_we);
    assign wmask0 = bus.d_req_wmask;
    assign addr0  = bus.d_req_addr;
    assign din0   = bus.d_req_wdata;
    assign csb1   = ~i_fire;
    assign addr1  = bus.i_req_addr;

    // Macro dout is only valid the cycle after acceptance; the flag marks that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_inflight <= 1'b0;
            i_inflight <= 1'b0;
        end else begin
            d_inflight <= d_rd_fire;
            i_inflight <= i_fire;
        end
    end

    assign d_pop = d_valid & bus.d_rsp_ready;
    assign i_pop = i_valid & bus.i_rsp_ready;

    sram_port_ctrl_rsp_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_d_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (d_inflight),
        .din   (dout0),
        .pop   (d_pop),
        .dout  (d_rdata),
        .valid (d_valid),
        .count (d_count)
    );

    sram_port_ctrl_rsp_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_i_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (i_inflight),
        .din   (dout1),
        .pop   (i_pop),
        .dout  (i_rdata),
        .valid (i_valid),
        .count (i_count)
    );

    assign bus.d_rsp_valid = d_valid;
    assign bus.d_rsp_rdata = d_rdata;
    assign bus.i_rsp_valid = i_valid;
    assign bus.i_rsp_rdata = i_rdata;
endmodule

// File: tb/tb_sram_port_ctrl.sv
// Scoreboard bench for sram_port_ctrl with a behavioural SRAM macro and a reference
// memory that predicts read data, response latency and ready/credit behaviour.
module tb_sram_port_ctrl;
    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int NM    = 4;
    localparam int DEPTH = 2;

    typedef struct {
        logic [DW-1:0] data;
        int            rdy;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_port_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NM)) bus ();

    logic          csb0, web0, csb1;
    logic [NM-1:0] wmask0;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] din0, dout0, dout1;

    sram_port_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_WMASKS (NM),
        .RSP_DEPTH  (DEPTH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .csb0   (csb0),
        .web0   (web0),
        .wmask0 (wmask0),
        .addr0  (addr0),
        .din0   (din0),
        .dout0  (dout0),
        .csb1   (csb1),
        .addr1  (addr1),
        .dout1  (dout1)
    );

    function automatic logic [DW-1:0] init_word(input int a);
        return (DW'(a) * 32'h0103_0507) ^ 32'h5A5A_0000;
    endfunction

    // Behavioural macro: pins sampled at posedge, dout valid for one cycle only.
    logic [DW-1:0] sram [256];
    logic          mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int a = 0; a < 256; a++) sram[a] <= init_word(a);
            mem_init <= 1'b1;
        end
        if (!csb0) begin
            if (!web0) begin
                for (int b = 0; b < NM; b++)
                    if (wmask0[b]) sram[addr0][8*b +: 8] <= din0[8*b +: 8];
                dout0 <= 'x;
            end else begin
                dout0 <= sram[addr0];
            end
        end else begin
            dout0 <= 'x;
        end
        if (!csb1) dout1 <= sram[addr1];
        else       dout1 <= 'x;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] ref_mem [256];
    exp_t dq[$];
    exp_t iq[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, DW'(act), DW'(exp));
    endtask

    // Runs at every negedge: predicts readies/valids, checks responses, records acceptances.
    task automatic sb_step();
        int  d_occ, i_occ;
        bit  d_pop, i_pop, hz, d_expv, i_expv;
        if (!rst_n) begin
            dq.delete();
            iq.delete();
            return;
        end
        d_pop = bus.d_rsp_valid && bus.d_rsp_ready;
        i_pop = bus.i_rsp_valid && bus.i_rsp_ready;
        d_occ = dq.size() - (d_pop ? 1 : 0);
        i_occ = iq.size() - (i_pop ? 1 : 0);
        hz = bus.d_req_valid && bus.d_req_we && (bus.d_req_addr == bus.i_req_addr);
        chk1("d_req_ready", bus.d_req_ready, bus.d_req_we ? 1'b1 : (d_occ < DEPTH));
        chk1("i_req_ready", bus.i_req_ready, !hz && (i_occ < DEPTH));
        d_expv = (dq.size() > 0) && (cyc >= dq[0].rdy);
        i_expv = (iq.size() > 0) && (cyc >= iq[0].rdy);
        chk1("d_rsp_valid", bus.d_rsp_valid, d_expv);
        chk1("i_rsp_valid", bus.i_rsp_valid, i_expv);
        if (bus.d_rsp_valid) begin
            if (dq.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL d_rsp_unexpected: got 0x%h, expected no response", bus.d_rsp_rdata);
            end else begin
                chk("d_rsp_rdata", bus.d_rsp_rdata, dq[0].data);
                if (d_pop) void'(dq.pop_front());
            end
        end
        if (bus.i_rsp_valid) begin
            if (iq.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL i_rsp_unexpected: got 0x%h, expected no response", bus.i_rsp_rdata);
            end else begin
                chk("i_rsp_rdata", bus.i_rsp_rdata, iq[0].data);
                if (i_pop) void'(iq.pop_front());
            end
        end
        if (bus.d_req_valid && bus.d_req_ready) begin
            if (bus.d_req_we) begin
                for (int b = 0; b < NM; b++)
                    if (bus.d_req_wmask[b])
                        ref_mem[bus.d_req_addr][8*b +: 8] = bus.d_req_wdata[8*b +: 8];
            end else begin
                dq.push_back('{data: ref_mem[bus.d_req_addr], rdy: cyc + 2});
            end
        end
        if (bus.i_req_valid && bus.i_req_ready)
            iq.push_back('{data: ref_mem[bus.i_req_addr], rdy: cyc + 2});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_d(input logic v, input logic we, input logic [NM-1:0] m,
                           input logic [AW-1:0] a, input logic [DW-1:0] wd);
        bus.d_req_valid = v;
        bus.d_req_we    = we;
        bus.d_req_wmask = m;
        bus.d_req_addr  = a;
        bus.d_req_wdata = wd;
    endtask

    task automatic drive_i(input logic v, input logic [AW-1:0] a);
        bus.i_req_valid = v;
        bus.i_req_addr  = a;
    endtask

    initial begin
        int  k, acc, dacc, iacc, guard;
        bit  took;
        for (int a = 0; a < 256; a++) ref_mem[a] = init_word(a);
        drive_d(1'b1, 1'b1, 4'hF, 8'h10, 32'h1111_1111);
        drive_i(1'b1, 8'h10);
        bus.d_rsp_ready = 1'b1;
        bus.i_rsp_ready = 1'b1;
        fork
            forever begin
                @(negedge clk);
                sb_step();
            end
        join_none

        // Reset state, with requests presented to show they are ignored.
        repeat (3) tick();
        chk1("rst_d_req_ready", bus.d_req_ready, 1'b0);
        chk1("rst_i_req_ready", bus.i_req_ready, 1'b0);
        chk1("rst_d_rsp_valid", bus.d_rsp_valid, 1'b0);
        chk1("rst_i_rsp_valid", bus.i_rsp_valid, 1'b0);
        chk("rst_d_rsp_rdata", bus.d_rsp_rdata, '0);
        chk("rst_i_rsp_rdata", bus.i_rsp_rdata, '0);
        chk1("rst_csb0", csb0, 1'b1);
        chk1("rst_csb1", csb1, 1'b1);
        chk1("rst_web0", web0, 1'b1);
        drive_d(1'b0, 1'b0, '0, '0, '0);
        drive_i(1'b0, '0);
        rst_n = 1'b1;
        #1;
        chk1("post_rst_d_ready", bus.d_req_ready, 1'b1);
        chk1("post_rst_i_ready", bus.i_req_ready, 1'b1);

        // Full-word write then read back.
        tick();
        drive_d(1'b1, 1'b1, 4'b1111, 8'h10, 32'hDEAD_BEEF);
        #1;
        chk1("wr_csb0", csb0, 1'b0);
        chk1("wr_web0", web0, 1'b0);
        chk("wr_addr0", DW'(addr0), 32'h10);
        chk("wr_din0", din0, 32'hDEAD_BEEF);
        chk("wr_wmask0", DW'(wmask0), 32'hF);
        tick();
        drive_d(1'b1, 1'b0, '0, 8'h10, '0);
        #1;
        chk1("rd_csb0", csb0, 1'b0);
        chk1("rd_web0", web0, 1'b1);
        tick();
        drive_d(1'b0, 1'b0, '0, '0, '0);
        #1;
        chk1("lat_early_valid", bus.d_rsp_valid, 1'b0);
        tick();
        chk1("lat_valid", bus.d_rsp_valid, 1'b1);
        chk("lat_rdata", bus.d_rsp_rdata, 32'hDEAD_BEEF);

        // Partial byte-lane write.
        tick();
        drive_d(1'b1, 1'b1, 4'b1111, 8'h55, 32'hFFFF_FFFF);
        tick();
        drive_d(1'b1, 1'b1, 4'b0101, 8'h55, 32'h0000_0000);
        tick();
        drive_d(1'b1, 1'b0, '0, 8'h55, '0);
        tick();
        drive_d(1'b0, 1'b0, '0, '0, '0);
        tick();
        chk("wmask_rdata", bus.d_rsp_rdata, 32'hFF00_FF00);

        // Credit limit with a stalled consumer.
        repeat (3) tick();
        bus.d_rsp_ready = 1'b0;
        k = 0; acc = 0;
        for (int c = 0; c < 6; c++) begin
            drive_d(1'b1, 1'b0, '0, AW'(8'h60 + k), '0);
            #1;
            took = bus.d_req_ready;
            tick();
            if (took) begin k++; acc++; end
        end
        chk("credit_accepts", DW'(acc), 32'd2);
        drive_d(1'b1, 1'b0, '0, AW'(8'h60 + k), '0);
        #1;
        chk1("credit_ready_low", bus.d_req_ready, 1'b0);
        bus.d_rsp_ready = 1'b1;
        guard = 0;
        while (k < 4 && guard < 20) begin
            drive_d(1'b1, 1'b0, '0, AW'(8'h60 + k), '0);
            #1;
            took = bus.d_req_ready;
            tick();
            if (took) k++;
            guard++;
        end
        chk("credit_resume", DW'(k), 32'd4);
        drive_d(1'b0, 1'b0, '0, '0, '0);
        repeat (6) tick();

        // Same-address write/fetch hazard and its non-hazard neighbours.
        drive_d(1'b1, 1'b1, 4'hF, 8'h20, 32'h1234_5678);
        drive_i(1'b1, 8'h20);
        #1;
        chk1("hz_i_ready", bus.i_req_ready, 1'b0);
        chk1("hz_d_ready", bus.d_req_ready, 1'b1);
        chk1("hz_csb1", csb1, 1'b1);
        tick();
        drive_d(1'b0, 1'b0, '0, '0, '0);
        #1;
        chk1("hz_retry_ready", bus.i_req_ready, 1'b1);
        tick();
        drive_i(1'b0, '0);
        tick();
        chk1("hz_rsp_valid", bus.i_rsp_valid, 1'b1);
        chk("hz_rsp_rdata", bus.i_rsp_rdata, 32'h1234_5678);
        drive_d(1'b1, 1'b1, 4'hF, 8'h21, 32'hCAFE_0001);
        drive_i(1'b1, 8'h22);
        #1;
        chk1("nohz_diff_addr", bus.i_req_ready, 1'b1);
        tick();
        drive_d(1'b1, 1'b0, '0, 8'h22, '0);
        #1;
        chk1("nohz_rd_rd_d", bus.d_req_ready, 1'b1);
        chk1("nohz_rd_rd_i", bus.i_req_ready, 1'b1);
        tick();
        drive_d(1'b0, 1'b0, '0, '0, '0);
        drive_i(1'b0, '0);
        repeat (4) tick();

        // Concurrent full-throughput reads on both channels.
        dacc = 0; iacc = 0;
        drive_d(1'b1, 1'b0, '0, 8'h30, '0);
        drive_i(1'b1, 8'h40);
        for (int c = 0; c < 8; c++) begin
            #1;
            if (bus.d_req_ready) dacc++;
            if (bus.i_req_ready) iacc++;
            tick();
        end
        chk("tput_d", DW'(dacc), 32'd8);
        chk("tput_i", DW'(iacc), 32'd8);
        drive_d(1'b0, 1'b0, '0, '0, '0);
        drive_i(1'b0, '0);
        repeat (4) tick();

        // Reset while reads are in flight.
        drive_d(1'b1, 1'b0, '0, 8'h10, '0);
        drive_i(1'b1, 8'h40);
        tick();
        rst_n = 1'b0;
        #1;
        chk1("mid_rst_csb0", csb0, 1'b1);
        chk1("mid_rst_csb1", csb1, 1'b1);
        chk1("mid_rst_d_ready", bus.d_req_ready, 1'b0);
        repeat (2) tick();
        drive_d(1'b0, 1'b0, '0, '0, '0);
        drive_i(1'b0, '0);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk1("post_rst_d_valid", bus.d_rsp_valid, 1'b0);
            chk1("post_rst_i_valid", bus.i_rsp_valid, 1'b0);
        end
        drive_d(1'b1, 1'b0, '0, 8'h10, '0);
        tick();
        drive_d(1'b0, 1'b0, '0, '0, '0);
        tick();
        chk1("fresh_rd_valid", bus.d_rsp_valid, 1'b1);
        chk("fresh_rd_rdata", bus.d_rsp_rdata, 32'hDEAD_BEEF);

        // Randomized traffic over a small address window to provoke hazards and stalls.
        for (int c = 0; c < 600; c++) begin
            tick();
            drive_d($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, NM'($urandom_range(0, 15)),
                    AW'($urandom_range(0, 7)), DW'($urandom));
            drive_i($urandom_range(0, 9) < 7, AW'($urandom_range(0, 7)));
            bus.d_rsp_ready = $urandom_range(0, 9) < 6;
            bus.i_rsp_ready = $urandom_range(0, 9) < 6;
        end
        tick();
        drive_d(1'b0, 1'b0, '0, '0, '0);
        drive_i(1'b0, '0);
        bus.d_rsp_ready = 1'b1;
        bus.i_rsp_ready = 1'b1;
        guard = 0;
        while ((dq.size() != 0 || iq.size() != 0) && guard < 20) begin
            tick();
            guard++;
        end
        chk("drain_d_pending", DW'(dq.size()), '0);
        chk("drain_i_pending", DW'(iq.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
